// File: rtl/ora_seq_check.sv
// ora_seq_check: buffered sink at a NoC ejection port that checks each packet's
// header fields and a running data counter, with optional LFSR-gated drain stalls.
module ora_seq_check #(
    parameter int i0_WIDTH     = 32,
    parameter int N            = 16,
    parameter int N_ADDR_WIDTH = $clog2(N),
    parameter int NODE         = 15,
    parameter int EXP_SRC      = 0,
    parameter int EXP_ID       = 0,
    parameter int i0_ID        = 0,
    parameter int DEPTH        = 4,
    parameter int STALL_EN     = 0,
    parameter int DONE_COUNT   = 100
) (
    input  logic                clk,
    input  logic                rst,
    output logic                done,
    input  logic [i0_WIDTH-1:0] i0_data_in,
    input  logic                i0_valid_in,
    output logic                i0_ready_out,
    output logic [15:0]         rx_count,
    output logic [15:0]         err_count,
    output logic [15:0]         drop_count,
    output logic                err_flag,
    output logic [i0_WIDTH-1:0] first_err_data
);
    localparam int AW    = N_ADDR_WIDTH;
    localparam int DW    = i0_WIDTH - 2*AW - 8;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_SKID  = CNT_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [AW-1:0]    SRC_C     = AW'(EXP_SRC);
    localparam logic [AW-1:0]    DST_C     = AW'(NODE);
    localparam logic [7:0]       ID_C      = 8'(EXP_ID);
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;
    localparam logic [15:0]      CNT_MAX   = 16'hFFFF;

    // The sink id only labels trace output; an out-of-range id or too-shallow FIFO is unsupported.
    if (DEPTH < 2 || DW < 1 || i0_ID < 0 || i0_ID > 255) begin : g_unsupported_params
    end

    logic [i0_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [DW-1:0]       exp_data_q, exp_data_d;
    logic [15:0]         rx_count_q, rx_count_d;
    logic [15:0]         err_count_q, err_count_d;
    logic [15:0]         drop_count_q, drop_count_d;
    logic                err_flag_q, err_flag_d;
    logic                done_q, done_d;
    logic [i0_WIDTH-1:0] first_err_q, first_err_d;

    logic                drain_en;
    logic                do_push;
    logic                do_pop;
    logic                do_drop;
    logic                pkt_ok;
    logic [i0_WIDTH-1:0] pop_pkt;
    logic [AW-1:0]       pkt_src;
    logic [AW-1:0]       pkt_dst;
    logic [7:0]          pkt_id;
    logic [DW-1:0]       pkt_data;

    assign pop_pkt  = mem_q[rd_ptr_q];
    assign pkt_src  = pop_pkt[i0_WIDTH-1 -: AW];
    assign pkt_dst  = pop_pkt[i0_WIDTH-AW-1 -: AW];
    assign pkt_id   = pop_pkt[DW+7:DW];
    assign pkt_data = pop_pkt[DW-1:0];

    // Drops are judged on the pre-pop occupancy, so a push can never overrun the buffer.
    always_comb begin
        drain_en = (STALL_EN != 0) ? lfsr_q[0] : 1'b1;
        do_pop   = (count_q != '0) && drain_en;
        do_push  = i0_valid_in && (count_q < CNT_FULL);
        do_drop  = i0_valid_in && (count_q == CNT_FULL);
        pkt_ok   = (pkt_src == SRC_C) && (pkt_dst == DST_C) &&
                   (pkt_id == ID_C) && (pkt_data == exp_data_q);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // A failing packet resyncs the expected counter so a single gap costs one error.
    always_comb begin
        rx_count_d   = rx_count_q;
        err_count_d  = err_count_q;
        drop_count_d = drop_count_q;
        exp_data_d   = exp_data_q;
        err_flag_d   = err_flag_q;
        first_err_d  = first_err_q;
        if (do_pop) begin
            if (rx_count_q != CNT_MAX) begin
                rx_count_d = rx_count_q + 16'd1;
            end
            if (pkt_ok) begin
                exp_data_d = exp_data_q + DW'(1);
            end else begin
                exp_data_d = pkt_data + DW'(1);
                if (err_count_q != CNT_MAX) begin
                    err_count_d = err_count_q + 16'd1;
                end
                if (!err_flag_q) begin
                    err_flag_d  = 1'b1;
                    first_err_d = pop_pkt;
                end
            end
        end
        if (do_drop && (drop_count_q != CNT_MAX)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
        done_d = done_q || (32'(rx_count_q) >= DONE_COUNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lfsr_q       <= LFSR_SEED;
            exp_data_q   <= DW'(1);
            rx_count_q   <= '0;
            err_count_q  <= '0;
            drop_count_q <= '0;
            err_flag_q   <= 1'b0;
            done_q       <= 1'b0;
            first_err_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            lfsr_q       <= lfsr_d;
            exp_data_q   <= exp_data_d;
            rx_count_q   <= rx_count_d;
            err_count_q  <= err_count_d;
            drop_count_q <= drop_count_d;
            err_flag_q   <= err_flag_d;
            done_q       <= done_d;
            first_err_q  <= first_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= i0_data_in;
        end
    end

    // Ready keeps one skid slot free because upstream samples it a cycle late.
    assign i0_ready_out   = (count_q < CNT_SKID);
    assign done           = done_q;
    assign rx_count       = rx_count_q;
    assign err_count      = err_count_q;
    assign drop_count     = drop_count_q;
    assign err_flag       = err_flag_q;
    assign first_err_data = first_err_q;

endmodule
